// File: rtl/alu_op_sequencer.sv
// Issue/capture stage: holds operands on the ALU for a per-op settle time, captures into z_hi/z_lo.
// Latency LAT edges accept->out_valid; result held until out_ready, no accept while waiting.
module alu_op_sequencer #(
    parameter int unsigned LAT_LOGIC  = 1,
    parameter int unsigned LAT_ADDSUB = 2,
    parameter int unsigned LAT_MULDIV = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  in_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_hi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z_lo,
    output logic [31:0] z_hi,
    output logic        op_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        capture;
    logic        op_illegal;
    logic        op_muldiv;
    logic        out_valid_d;

    // Counter preload is settle time minus one: exit happens on the edge where cnt is already zero.
    function automatic logic [3:0] lat_m1(input logic [3:0] op);
        logic [3:0] r;
        r = 4'(LAT_LOGIC - 1);
        if (op[3:1] == 3'b100) begin
            r = 4'(LAT_ADDSUB - 1);
        end else if (op[3:1] == 3'b101) begin
            r = 4'(LAT_MULDIV - 1);
        end else if (op[3:2] == 2'b11) begin
            r = 4'd0;
        end
        return r;
    endfunction

    assign in_ready   = clr & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept     = in_valid & in_ready;
    assign capture    = (state_q == WAIT) && (cnt_q == 4'd0);
    assign op_illegal = (alu_op[3:2] == 2'b11);
    assign op_muldiv  = (alu_op[3:1] == 3'b101);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = lat_m1(in_op);
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        state_d = WAIT;
                        cnt_d   = lat_m1(in_op);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = 4'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
        end
    end

    // ALU inputs move only on accept, so the whole WAIT window is a stable multicycle path.
    always_ff @(posedge clk) begin
        if (!clr) begin
            alu_a  <= 32'd0;
            alu_b  <= 32'd0;
            alu_op <= 4'd0;
        end else if (accept) begin
            alu_a  <= in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            z_lo   <= 32'd0;
            z_hi   <= 32'd0;
            op_err <= 1'b0;
        end else if (capture) begin
            z_lo   <= op_illegal ? 32'd0 : alu_result;
            z_hi   <= op_muldiv ? alu_hi : 32'd0;
            op_err <= op_illegal;
        end
    end

endmodule
